// File: rtl/reg_scoreboard_if.sv
// Issue / writeback / status bundle for the register scoreboard.
// The scoreboard takes the slave modport; the ID/WB stages take the master modport.
interface reg_scoreboard_if;
  logic        issue_valid_i;
  logic        issue_ack_o;
  logic [4:0]  issue_rs1_i;
  logic [4:0]  issue_rs2_i;
  logic [4:0]  issue_rd_i;
  logic        issue_wr_i;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic        flush_i;
  logic [31:0] pending_o;
  logic        busy_o;
  logic        err_o;

  modport master (
    output issue_valid_i, issue_rs1_i, issue_rs2_i, issue_rd_i, issue_wr_i,
    output wb_valid_i, wb_rd_i, flush_i,
    input  issue_ack_o, pending_o, busy_o, err_o
  );

  modport slave (
    input  issue_valid_i, issue_rs1_i, issue_rs2_i, issue_rd_i, issue_wr_i,
    input  wb_valid_i, wb_rd_i, flush_i,
    output issue_ack_o, pending_o, busy_o, err_o
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard gating instruction issue on RAW and counter saturation.
// Optional macro SCOREBOARD_WB_BYPASS_EN: a source with one pending write retiring this cycle is not a hazard.
module reg_scoreboard #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rstn_i,
  reg_scoreboard_if.slave  sb
);

  localparam int unsigned NREG = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt     [NREG];
  logic [CNT_W-1:0] cnt_nxt [NREG];
  logic [NREG-1:0]  pending_nxt;
  logic             err_nxt;
  logic             rs1_haz;
  logic             rs2_haz;
  logic             rd_sat;
  logic             rs1_byp;
  logic             rs2_byp;
  logic             ack_c;

`ifdef SCOREBOARD_WB_BYPASS_EN
  // Write-through register file: last pending write landing now satisfies the read
  assign rs1_byp = sb.wb_valid_i && (sb.wb_rd_i == sb.issue_rs1_i) && (cnt[sb.issue_rs1_i] == CNT_ONE);
  assign rs2_byp = sb.wb_valid_i && (sb.wb_rd_i == sb.issue_rs2_i) && (cnt[sb.issue_rs2_i] == CNT_ONE);
`else
  assign rs1_byp = 1'b0;
  assign rs2_byp = 1'b0;
`endif

  assign rs1_haz = (sb.issue_rs1_i != 5'd0) && (cnt[sb.issue_rs1_i] != '0) && !rs1_byp;
  assign rs2_haz = (sb.issue_rs2_i != 5'd0) && (cnt[sb.issue_rs2_i] != '0) && !rs2_byp;
  assign rd_sat  = sb.issue_wr_i && (cnt[sb.issue_rd_i] == CNT_MAX);

  assign ack_c          = sb.issue_valid_i && !(rs1_haz || rs2_haz || rd_sat) && !sb.flush_i;
  assign sb.issue_ack_o = ack_c;

  // Counter update: flush clears, same-register issue+writeback cancels, never wraps
  always_comb begin
    for (int i = 0; i < int'(NREG); i++) begin
      logic inc;
      logic dec;
      cnt_nxt[i] = cnt[i];
      inc = ack_c && sb.issue_wr_i && (sb.issue_rd_i == 5'(i));
      dec = sb.wb_valid_i && (sb.wb_rd_i == 5'(i));
      if (i == 0 || sb.flush_i) begin
        cnt_nxt[i] = '0;
      end else if (inc && !dec) begin
        cnt_nxt[i] = cnt[i] + CNT_ONE;
      end else if (dec && !inc && (cnt[i] != '0)) begin
        cnt_nxt[i] = cnt[i] - CNT_ONE;
      end
      pending_nxt[i] = (cnt_nxt[i] != '0);
    end
  end

  assign err_nxt = sb.wb_valid_i && (sb.wb_rd_i != 5'd0) && (cnt[sb.wb_rd_i] == '0) && !sb.flush_i;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < int'(NREG); i++) cnt[i] <= '0;
      sb.pending_o <= '0;
      sb.busy_o    <= 1'b0;
      sb.err_o     <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NREG); i++) cnt[i] <= cnt_nxt[i];
      sb.pending_o <= pending_nxt;
      sb.busy_o    <= |pending_nxt;
      sb.err_o     <= err_nxt;
    end
  end

endmodule
